// File: rtl/vote_pkg.sv
// +-------------------------------------------------------------------------+
// | vote_pkg: default sizing and arbiter state encoding for the vote block. |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
`default_nettype none

package vote_pkg;

  localparam int unsigned DEF_N_BTN        = 4;
  localparam int unsigned DEF_HOLD_CYCLES  = 10;
  localparam int unsigned DEF_STUCK_CYCLES = 1000000;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  // Counter just wide enough to hold the saturation value without wrapping.
  function automatic int unsigned cnt_width(input int unsigned stuck_cycles);
    return $clog2(stuck_cycles + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/btn_channel.sv
// +-------------------------------------------------------------------------+
// | btn_channel: one button's conditioning, hold counter, qualify and stuck |
// | flag. Optional 2-flop input synchroniser under MULTI_BUTTON_SYNC_EN.    |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
`default_nettype none

module btn_channel
  import vote_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES  = DEF_HOLD_CYCLES,
  parameter int unsigned STUCK_CYCLES = DEF_STUCK_CYCLES
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_i,
  output logic level_o,
  output logic qualify_o,
  output logic stuck_o
);

  localparam int unsigned          CNT_W   = cnt_width(STUCK_CYCLES);
  localparam logic [CNT_W-1:0]     C_HOLD  = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0]     C_STUCK = CNT_W'(STUCK_CYCLES);
  localparam logic [CNT_W-1:0]     C_ONE   = CNT_W'(1);

  logic             w_level;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

`ifdef MULTI_BUTTON_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], btn_i};
    end
  end

  assign w_level = sync_q[1];
`else
  assign w_level = btn_i;
`endif

  always_comb begin
    cnt_d = '0;
    if (w_level) begin
      cnt_d = (cnt_q == C_STUCK) ? cnt_q : (cnt_q + C_ONE);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The counter passes through C_HOLD exactly once per press, so a single
  // compare gives the one-shot qualification.
  assign qualify_o = (cnt_q == C_HOLD);
  assign stuck_o   = (cnt_q == C_STUCK);
  assign level_o   = w_level;

endmodule

`default_nettype wire

// File: rtl/multi_button_debounce.sv
// +-------------------------------------------------------------------------+
// | multi_button_debounce: per-button debounce plus single-vote arbiter.    |
// | Build option: MULTI_BUTTON_SYNC_EN adds a 2-flop input synchroniser.    |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
`default_nettype none

module multi_button_debounce
  import vote_pkg::*;
#(
  parameter int unsigned N_BTN        = DEF_N_BTN,
  parameter int unsigned HOLD_CYCLES  = DEF_HOLD_CYCLES,
  parameter int unsigned STUCK_CYCLES = DEF_STUCK_CYCLES
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [N_BTN-1:0]         button,
  input  logic                     enable,
  output logic                     vote_valid,
  output logic [$clog2(N_BTN)-1:0] vote_id,
  output logic                     multi_press,
  output logic [N_BTN-1:0]         stuck
);

  localparam int unsigned ID_W = $clog2(N_BTN);

  logic [N_BTN-1:0] level;
  logic [N_BTN-1:0] qualify;

  genvar gi;
  generate
    for (gi = 0; gi < N_BTN; gi++) begin : g_chan
      btn_channel #(
        .HOLD_CYCLES  (HOLD_CYCLES),
        .STUCK_CYCLES (STUCK_CYCLES)
      ) u_chan (
        .clock     (clock),
        .reset     (reset),
        .btn_i     (button[gi]),
        .level_o   (level[gi]),
        .qualify_o (qualify[gi]),
        .stuck_o   (stuck[gi])
      );
    end
  endgenerate

  arb_state_e        state_q;
  arb_state_e        state_d;
  logic              vote_valid_q;
  logic              vote_valid_d;
  logic [ID_W-1:0]   vote_id_q;
  logic [ID_W-1:0]   vote_id_d;
  logic              multi_q;
  logic              multi_d;

  logic              any_qual;
  logic              single_qual;
  logic [ID_W-1:0]   qual_idx;

  assign any_qual    = |qualify;
  assign single_qual = any_qual && ((qualify & (qualify - N_BTN'(1))) == '0);

  always_comb begin
    qual_idx = '0;
    for (int i = 0; i < N_BTN; i++) begin
      if (qualify[i]) begin
        qual_idx = ID_W'(i);
      end
    end
  end

  // Qualifications seen with enable low are simply dropped; the channel will
  // not qualify again until its button is released and pressed anew.
  always_comb begin
    state_d      = state_q;
    vote_valid_d = 1'b0;
    vote_id_d    = '0;
    multi_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable && any_qual) begin
          state_d = LOCKED;
          if (single_qual) begin
            vote_valid_d = 1'b1;
            vote_id_d    = qual_idx;
          end else begin
            multi_d = 1'b1;
          end
        end
      end
      LOCKED: begin
        if (level == '0) begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      vote_valid_q <= 1'b0;
      vote_id_q    <= '0;
      multi_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      vote_valid_q <= vote_valid_d;
      vote_id_q    <= vote_id_d;
      multi_q      <= multi_d;
    end
  end

  assign vote_valid  = vote_valid_q;
  assign vote_id     = vote_id_q;
  assign multi_press = multi_q;

endmodule

`default_nettype wire

// File: tb/tb_multi_button_debounce.sv
// +-------------------------------------------------------------------------+
// | tb_multi_button_debounce: directed scenarios for the vote debouncer.    |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
`default_nettype none

module tb_multi_button_debounce;

  localparam int N     = 4;
  localparam int HOLD  = 10;
  localparam int STUCK = 50;
`ifdef MULTI_BUTTON_SYNC_EN
  localparam int SYNC  = 2;
`else
  localparam int SYNC  = 0;
`endif
  localparam int LAT   = HOLD + 1 + SYNC;

  logic         clock  = 1'b0;
  logic         reset  = 1'b1;
  logic         enable = 1'b1;
  logic [N-1:0] button = '0;
  logic         vote_valid;
  logic [1:0]   vote_id;
  logic         multi_press;
  logic [N-1:0] stuck;

  int tests = 0;
  int fails = 0;
  int edge_n = 0;
  int votes, multis, last_id, vote_edge;
  int both = 0;
  int idle_id_bad = 0;
  int k;

  multi_button_debounce #(
    .N_BTN        (N),
    .HOLD_CYCLES  (HOLD),
    .STUCK_CYCLES (STUCK)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .button      (button),
    .enable      (enable),
    .vote_valid  (vote_valid),
    .vote_id     (vote_id),
    .multi_press (multi_press),
    .stuck       (stuck)
  );

  initial forever #5 clock = ~clock;

  task automatic run_cycles(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clock);
      #1;
      edge_n++;
      if (vote_valid === 1'b1) begin
        votes++;
        last_id   = int'(vote_id);
        vote_edge = edge_n;
      end else if (vote_id !== 2'd0) begin
        idle_id_bad++;
      end
      if (multi_press === 1'b1) multis++;
      if (vote_valid === 1'b1 && multi_press === 1'b1) both++;
    end
  endtask

  task automatic clear_stats();
    votes = 0; multis = 0; last_id = -1; vote_edge = -1;
  endtask

  task automatic settle();
    button = '0;
    run_cycles(SYNC + 4);
    clear_stats();
  endtask

  task automatic test_reset();
    reset = 1'b1; button = '0; clear_stats();
    run_cycles(3);
    tests++; if (vote_valid !== 1'b0) begin fails++; $display("FAIL reset_vote_valid: got %b expected 0", vote_valid); end
    tests++; if (vote_id !== 2'd0) begin fails++; $display("FAIL reset_vote_id: got %0d expected 0", vote_id); end
    tests++; if (multi_press !== 1'b0) begin fails++; $display("FAIL reset_multi: got %b expected 0", multi_press); end
    tests++; if (stuck !== 4'b0000) begin fails++; $display("FAIL reset_stuck: got %b expected 0000", stuck); end
    reset = 1'b0;
    run_cycles(3);
    tests++; if (votes !== 0) begin fails++; $display("FAIL reset_quiet: got %0d votes expected 0", votes); end
    clear_stats();
  endtask

  task automatic test_single_vote();
    clear_stats(); k = edge_n;
    button = 4'b0100; run_cycles(20);
    button = 4'b0000; run_cycles(20);
    tests++; if (votes !== 1) begin fails++; $display("FAIL single_count: got %0d expected 1", votes); end
    tests++; if (last_id !== 2) begin fails++; $display("FAIL single_id: got %0d expected 2", last_id); end
    tests++; if (vote_edge !== k + LAT) begin fails++; $display("FAIL single_latency: got edge %0d expected %0d", vote_edge - k, LAT); end
    tests++; if (multis !== 0) begin fails++; $display("FAIL single_multi: got %0d expected 0", multis); end
    settle();
  endtask

  task automatic test_glitch();
    clear_stats();
    button = 4'b0010; run_cycles(8);
    button = 4'b0000; run_cycles(1);
    button = 4'b0010; run_cycles(8);
    button = 4'b0000; run_cycles(10);
    tests++; if (votes !== 0) begin fails++; $display("FAIL glitch_votes: got %0d expected 0", votes); end
    settle();
  endtask

  task automatic test_multi();
    clear_stats();
    button = 4'b1001; run_cycles(15);
    button = 4'b0000; run_cycles(SYNC + 3);
    tests++; if (multis !== 1) begin fails++; $display("FAIL multi_count: got %0d expected 1", multis); end
    tests++; if (votes !== 0) begin fails++; $display("FAIL multi_votes: got %0d expected 0", votes); end
    clear_stats(); k = edge_n;
    button = 4'b1000; run_cycles(20);
    button = 4'b0000; run_cycles(SYNC + 3);
    tests++; if (votes !== 1 || last_id !== 3) begin fails++; $display("FAIL multi_after: got %0d votes id %0d expected 1 id 3", votes, last_id); end
    tests++; if (vote_edge !== k + LAT) begin fails++; $display("FAIL multi_after_latency: got %0d expected %0d", vote_edge - k, LAT); end
    settle();
  endtask

  task automatic test_locked();
    clear_stats();
    button = 4'b0010; run_cycles(20);
    tests++; if (votes !== 1 || last_id !== 1) begin fails++; $display("FAIL locked_first: got %0d votes id %0d expected 1 id 1", votes, last_id); end
    clear_stats();
    button = 4'b0110; run_cycles(20);
    button = 4'b0100; run_cycles(10);
    button = 4'b0000; run_cycles(SYNC + 3);
    tests++; if (votes !== 0 || multis !== 0) begin fails++; $display("FAIL locked_hold: got %0d votes %0d multi expected 0 0", votes, multis); end
    clear_stats();
    button = 4'b0100; run_cycles(20);
    button = 4'b0000; run_cycles(SYNC + 3);
    tests++; if (votes !== 1 || last_id !== 2) begin fails++; $display("FAIL locked_release: got %0d votes id %0d expected 1 id 2", votes, last_id); end
    settle();
  endtask

  task automatic test_stuck();
    clear_stats();
    button = 4'b0001; run_cycles(SYNC + 49);
    tests++; if (stuck !== 4'b0000) begin fails++; $display("FAIL stuck_early: got %b expected 0000", stuck); end
    run_cycles(1);
    tests++; if (stuck !== 4'b0001) begin fails++; $display("FAIL stuck_set: got %b expected 0001", stuck); end
    run_cycles(60 - SYNC - 50);
    tests++; if (stuck !== 4'b0001) begin fails++; $display("FAIL stuck_held: got %b expected 0001", stuck); end
    tests++; if (votes !== 1 || last_id !== 0) begin fails++; $display("FAIL stuck_vote: got %0d votes id %0d expected 1 id 0", votes, last_id); end
    button = 4'b0000; run_cycles(SYNC);
    tests++; if (stuck !== 4'b0001) begin fails++; $display("FAIL stuck_pipe: got %b expected 0001", stuck); end
    run_cycles(1);
    tests++; if (stuck !== 4'b0000) begin fails++; $display("FAIL stuck_clear: got %b expected 0000", stuck); end
    settle();
  endtask

  task automatic test_enable();
    clear_stats();
    enable = 1'b0;
    button = 4'b0100; run_cycles(15);
    enable = 1'b1; run_cycles(5);
    button = 4'b0000; run_cycles(SYNC + 3);
    tests++; if (votes !== 0 || multis !== 0) begin fails++; $display("FAIL enable_blocked: got %0d votes %0d multi expected 0 0", votes, multis); end
    clear_stats(); k = edge_n;
    button = 4'b0100; run_cycles(20);
    button = 4'b0000; run_cycles(SYNC + 3);
    tests++; if (votes !== 1 || last_id !== 2) begin fails++; $display("FAIL enable_repress: got %0d votes id %0d expected 1 id 2", votes, last_id); end
    tests++; if (vote_edge !== k + LAT) begin fails++; $display("FAIL enable_latency: got %0d expected %0d", vote_edge - k, LAT); end
    settle();
  endtask

  task automatic test_reset_mid_press();
    clear_stats();
    button = 4'b0010; run_cycles(5);
    reset = 1'b1; run_cycles(2);
    reset = 1'b0; k = edge_n;
    tests++; if (votes !== 0) begin fails++; $display("FAIL midreset_none: got %0d votes expected 0", votes); end
    run_cycles(20);
    button = 4'b0000; run_cycles(SYNC + 3);
    tests++; if (votes !== 1 || last_id !== 1) begin fails++; $display("FAIL midreset_vote: got %0d votes id %0d expected 1 id 1", votes, last_id); end
    tests++; if (vote_edge !== k + LAT) begin fails++; $display("FAIL midreset_latency: got %0d expected %0d", vote_edge - k, LAT); end
    settle();
  endtask

  task automatic test_back_to_back();
    clear_stats();
    button = 4'b0001; run_cycles(LAT + 1);
    button = 4'b0000; run_cycles(SYNC + 1);
    button = 4'b1000; run_cycles(LAT + 1);
    button = 4'b0000; run_cycles(SYNC + 3);
    tests++; if (votes !== 2 || last_id !== 3) begin fails++; $display("FAIL b2b_votes: got %0d votes id %0d expected 2 id 3", votes, last_id); end
    settle();
  endtask

  initial begin
    clear_stats();
    test_reset();
    test_single_vote();
    test_glitch();
    test_multi();
    test_locked();
    test_stuck();
    test_enable();
    test_reset_mid_press();
    test_back_to_back();
    tests++; if (both !== 0) begin fails++; $display("FAIL vote_and_multi: got %0d overlaps expected 0", both); end
    tests++; if (idle_id_bad !== 0) begin fails++; $display("FAIL idle_vote_id: got %0d nonzero cycles expected 0", idle_id_bad); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
